// File: rtl/spi_target_regs.sv
// SPI mode-0 target with an 8 x 8-bit register file, oversampled in the clk domain.
// Optional: define SPI_TARGET_AUTOINC_EN for address auto-increment bursts.
module spi_target_regs #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       rx_valid,
    output logic [2:0] rx_addr,
    output logic [7:0] rx_data,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;

    logic [1:0] r_state;
    logic [2:0] r_bitcnt;
    logic [6:0] r_shift_in;
    logic [7:0] r_shift_out;
    logic       r_rw;
    logic [2:0] r_addr;
    logic       r_wr_pend;
    logic [2:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic       r_miso;
    logic       r_miso_oe;
    logic       r_rx_valid;
    logic [2:0] r_rx_addr;
    logic [7:0] r_rx_data;
    logic [7:0] r_regs [0:7];

    logic       w_sclk;
    logic       w_mosi;
    logic       w_sel;
    logic       w_rise;
    logic       w_fall;
    logic [7:0] w_byte;
    logic [2:0] w_cmd_addr;
    logic [7:0] w_cmd_val;

    assign w_sclk     = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sel      = ena & ~r_cs_sync[SYNC_STAGES-1];
    assign w_rise     = w_sclk & ~r_sclk_d;
    assign w_fall     = ~w_sclk & r_sclk_d;
    assign w_byte     = {r_shift_in, w_mosi};
    assign w_cmd_addr = w_byte[2:0];
    assign w_cmd_val  = (w_cmd_addr == 3'd7) ? ID_VALUE : r_regs[w_cmd_addr];

`ifdef SPI_TARGET_AUTOINC_EN
    logic [2:0] w_addr_inc;
    logic [7:0] w_inc_val;
    assign w_addr_inc = r_addr + 3'd1;
    assign w_inc_val  = (w_addr_inc == 3'd7) ? ID_VALUE : r_regs[w_addr_inc];
`endif

    assign dbg_data    = (dbg_addr == 3'd7) ? ID_VALUE : r_regs[dbg_addr];
    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_miso_oe;
    assign rx_valid    = r_rx_valid;
    assign rx_addr     = r_rx_addr;
    assign rx_data     = r_rx_data;

    // Synchronizers flush to the idle bus level (sclk low, cs_n high, mosi low).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sclk_d    <= w_sclk;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bitcnt    <= '0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wr_pend   <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_addr   <= '0;
            r_rx_data   <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_pend  <= 1'b0;
            r_rx_valid <= r_wr_pend;
            if (r_wr_pend) begin
                r_rx_addr <= r_wr_addr;
                r_rx_data <= r_wr_data;
            end
            // Deselect takes priority over any coincident SCLK edge.
            if (r_state != S_IDLE && !w_sel) begin
                r_state   <= S_IDLE;
                r_bitcnt  <= '0;
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_sel) begin
                            r_state   <= S_CMD;
                            r_bitcnt  <= '0;
                            r_miso    <= 1'b0;
                            r_miso_oe <= 1'b1;
                        end
                    end
                    S_CMD: begin
                        if (w_rise) begin
                            r_shift_in <= w_byte[6:0];
                            r_bitcnt   <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_rw        <= w_byte[7];
                                r_addr      <= w_cmd_addr;
                                r_shift_out <= w_cmd_val;
                                r_state     <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_rise) begin
                            r_shift_in <= w_byte[6:0];
                            r_bitcnt   <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                if (!r_rw && r_addr != 3'd7) begin
                                    r_regs[r_addr] <= w_byte;
                                    r_wr_pend      <= 1'b1;
                                    r_wr_addr      <= r_addr;
                                    r_wr_data      <= w_byte;
                                end
`ifdef SPI_TARGET_AUTOINC_EN
                                r_addr      <= w_addr_inc;
                                r_shift_out <= w_inc_val;
`else
                                r_state <= S_DONE;
                                r_miso  <= 1'b0;
`endif
                            end
                        end else if (w_fall && r_rw) begin
                            r_miso      <= r_shift_out[7];
                            r_shift_out <= {r_shift_out[6:0], 1'b0};
                        end
                    end
                    default: begin
                        r_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_target_regs.sv
// Directed, table-driven bench for spi_target_regs (honours SPI_TARGET_AUTOINC_EN).
module tb_spi_target_regs;

    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       rx_valid;
    logic [2:0] rx_addr;
    logic [7:0] rx_data;
    logic [2:0] dbg_addr = 3'd0;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    spi_target_regs #(.SYNC_STAGES(2), .ID_VALUE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .rx_valid(rx_valid), .rx_addr(rx_addr), .rx_data(rx_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && rx_valid) pulse_cnt++;
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        int         exp_pulses;
        logic [2:0] exp_addr;
        logic [7:0] exp_rdata;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = b[i];
            #HALF;
            r[i] = spi_miso;
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_frame2(input logic [7:0] c, input logic [7:0] d,
                              output logic [7:0] m1, output logic [7:0] m2);
        spi_cs_n = 1'b0;
        #HALF;
        spi_byte(c, m1);
        spi_byte(d, m2);
        #HALF;
        spi_cs_n = 1'b1;
        #(2 * HALF);
    endtask

    initial begin
        logic [7:0] m1, m2, m3;
        logic [7:0] exp_regs[8];
        int p0;
        int lat;

        vecs[0] = '{8'h03, 8'h5C, 1, 3'd3, 8'h5C, 8'h00};
        vecs[1] = '{8'h83, 8'h00, 0, 3'd3, 8'h5C, 8'h5C};
        vecs[2] = '{8'h07, 8'hFF, 0, 3'd3, 8'h5C, 8'h00};
        vecs[3] = '{8'h87, 8'h00, 0, 3'd3, 8'h5C, 8'hA5};
        vecs[4] = '{8'h7D, 8'h3C, 1, 3'd5, 8'h3C, 8'h00};
        vecs[5] = '{8'hF5, 8'h00, 0, 3'd5, 8'h3C, 8'h3C};
        vecs[6] = '{8'h00, 8'h81, 1, 3'd0, 8'h81, 8'h00};
        vecs[7] = '{8'h80, 8'h00, 0, 3'd0, 8'h81, 8'h81};
        vecs[8] = '{8'h06, 8'hE7, 1, 3'd6, 8'hE7, 8'h00};
        vecs[9] = '{8'h86, 8'h00, 0, 3'd6, 8'hE7, 8'hE7};
        exp_regs = '{8'h81, 8'h00, 8'h00, 8'h5C, 8'h00, 8'h3C, 8'hE7, 8'hA5};

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("reset_oe", spi_miso_oe, 1'b0);
        chk("reset_rx_valid", rx_valid, 1'b0);
        chk("reset_rx_addr", rx_addr, 3'd0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk("reset_dbg", dbg_data, (i == 7) ? 8'hA5 : 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            p0 = pulse_cnt;
            spi_frame2(vecs[v].cmd, vecs[v].data, m1, m2);
            chk("vec_pulses", pulse_cnt - p0, vecs[v].exp_pulses);
            chk("vec_rx_addr", rx_addr, vecs[v].exp_addr);
            chk("vec_rx_data", rx_data, vecs[v].exp_rdata);
            chk("vec_miso_cmd", m1, 8'h00);
            chk("vec_miso_data", m2, vecs[v].exp_miso);
            chk("vec_idle_oe", spi_miso_oe, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk("dbg_read", dbg_data, exp_regs[i]);
        end
        @(negedge clk);

        // Abort mid-byte
        p0 = pulse_cnt;
        spi_cs_n = 1'b0;
        #HALF;
        spi_byte(8'h02, m1);
        for (int i = 0; i < 5; i++) begin
            spi_mosi = 1'b1;
            #HALF;
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
        end
        chk("abort_oe_sel", spi_miso_oe, 1'b1);
        spi_cs_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_oe_off", spi_miso_oe, 1'b0);
        chk("abort_miso", spi_miso, 1'b0);
        @(negedge clk);
        #(2 * HALF);
        chk("abort_pulses", pulse_cnt - p0, 0);
        dbg_addr = 3'd2;
        #1;
        chk("abort_reg2", dbg_data, 8'h00);
        @(negedge clk);
        p0 = pulse_cnt;
        spi_frame2(8'h02, 8'h4B, m1, m2);
        chk("post_abort_pulses", pulse_cnt - p0, 1);
        dbg_addr = 3'd2;
        #1;
        chk("post_abort_reg2", dbg_data, 8'h4B);
        @(negedge clk);

        // Disabled block ignores the bus
        ena = 1'b0;
        p0 = pulse_cnt;
        spi_cs_n = 1'b0;
        #HALF;
        spi_byte(8'h01, m1);
        chk("ena_oe", spi_miso_oe, 1'b0);
        spi_byte(8'hAA, m2);
        #HALF;
        spi_cs_n = 1'b1;
        #(2 * HALF);
        chk("ena_pulses", pulse_cnt - p0, 0);
        dbg_addr = 3'd1;
        #1;
        chk("ena_reg1", dbg_data, 8'h00);
        @(negedge clk);
        ena = 1'b1;
        #(2 * HALF);

        // Latency from last SCLK rise to rx_valid
        lat = 0;
        spi_cs_n = 1'b0;
        #HALF;
        spi_byte(8'h04, m1);
        for (int i = 7; i >= 1; i--) begin
            spi_mosi = i[0];
            #HALF;
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
        end
        spi_mosi = 1'b0;
        #HALF;
        spi_sclk = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (rx_valid && lat == 0) lat = k;
        end
        @(negedge clk);
        spi_sclk = 1'b0;
        #HALF;
        spi_cs_n = 1'b1;
        #(2 * HALF);
        chk("latency", lat, 4);
        chk("latency_rx_addr", rx_addr, 3'd4);
        chk("latency_rx_data", rx_data, 8'hAA);

        // Burst write 06,11,22,33
        p0 = pulse_cnt;
        spi_cs_n = 1'b0;
        #HALF;
        spi_byte(8'h06, m1);
        spi_byte(8'h11, m2);
        spi_byte(8'h22, m3);
        spi_byte(8'h33, m3);
        #HALF;
        spi_cs_n = 1'b1;
        #(2 * HALF);
        dbg_addr = 3'd6;
        #1;
        chk("burst_reg6", dbg_data, 8'h11);
        dbg_addr = 3'd7;
        #1;
        chk("burst_reg7", dbg_data, 8'hA5);
        dbg_addr = 3'd0;
        #1;
`ifdef SPI_TARGET_AUTOINC_EN
        chk("burst_reg0", dbg_data, 8'h33);
        chk("burst_pulses", pulse_cnt - p0, 2);
        chk("burst_rx_addr", rx_addr, 3'd0);
        chk("burst_rx_data", rx_data, 8'h33);
`else
        chk("burst_reg0", dbg_data, 8'h81);
        chk("burst_pulses", pulse_cnt - p0, 1);
        chk("burst_rx_addr", rx_addr, 3'd6);
        chk("burst_rx_data", rx_data, 8'h11);
`endif
        @(negedge clk);

        // Burst read 85 then two data bytes
        spi_cs_n = 1'b0;
        #HALF;
        spi_byte(8'h85, m1);
        spi_byte(8'h00, m2);
        spi_byte(8'h00, m3);
        #HALF;
        spi_cs_n = 1'b1;
        #(2 * HALF);
        chk("rburst_byte1", m2, 8'h3C);
`ifdef SPI_TARGET_AUTOINC_EN
        chk("rburst_byte2", m3, 8'h11);
`else
        chk("rburst_byte2", m3, 8'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_target_regs.md
Name: spi_target_regs

Overview:
- SPI mode-0 target (slave) with an 8-entry x 8-bit register file.
- It is the far end of the I2C-to-SPI bridge's SPI master. It lets the bridge be looped back and verified on-chip, and it exposes a small configuration space to an external SPI host.
- All SPI pins are oversampled in the system clock domain. There is no SCLK-clocked logic.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on spi_sclk, spi_cs_n and spi_mosi. Minimum 2.
- ID_VALUE, 8'hA5, read-only contents of register 7.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ena  in  1  block enable. While low, the block behaves as if spi_cs_n were high.
- spi_sclk  in  1  SPI clock from the master, asynchronous.
- spi_cs_n  in  1  chip select, active low, asynchronous.
- spi_mosi  in  1  master-out data, asynchronous.
- spi_miso  out  1  target-out data.
- spi_miso_oe  out  1  output enable for spi_miso. High while selected.
- rx_valid  out  1  one-clk pulse when a register write commits.
- rx_addr  out  3  address of the last committed write.
- rx_data  out  8  data of the last committed write.
- dbg_addr  in  3  local read address.
- dbg_data  out  8  combinational read of regfile[dbg_addr]. Returns ID_VALUE when dbg_addr = 7.

Behaviour:
- Reset (rst_n low at a clk edge):
  - regs 0-6 = 8'h00.
  - spi_miso = 0, spi_miso_oe = 0, rx_valid = 0, rx_addr = 0, rx_data = 0.
  - FSM = IDLE, bit counter = 0.
  - Synchronizers flush to the idle level: sclk = 0, cs_n = 1, mosi = 0.
- Sampling: each input passes through SYNC_STAGES flops. Edges are detected by comparing the last synchronized value with a one-flop delayed copy. Requirement: SCLK high and low phases are each at least 4 clk periods.
- Frame: cs_n falling, then a command byte, then data byte(s), then cs_n rising.
  - Bits are MSB first. MOSI is sampled on synced SCLK rising edges. MISO changes on synced SCLK falling edges.
  - Command byte: bit7 = 1 read / 0 write; bits6:3 ignored; bits2:0 = address.
- FSM states IDLE, CMD, DATA, DONE:
  - IDLE -> CMD on synced cs_n = 0. Bit counter cleared, spi_miso_oe = 1, spi_miso = 0.
  - CMD: shift in 8 bits. On the 8th rising edge, latch rw and addr, then go to DATA.
    - Read: load shift_out with the register value, or ID_VALUE for address 7.
  - DATA, write: on the 8th rising edge, commit to regfile[addr].
    - rx_valid pulses for exactly 1 clk in the cycle after the commit. rx_addr and rx_data update in that same cycle and hold until the next commit.
    - Write to address 7: ignored. No rx_valid pulse.
  - DATA, read: each falling edge presents shift_out[7], then shifts left.
    - The first falling edge after the CMD byte's 8th rising edge presents bit 7.
    - The regfile is not modified.
  - DATA -> DONE after 8 data bits. In DONE, further bits are ignored and spi_miso = 0.
- cs_n rising in any state, including mid-byte: go to IDLE next clk.
  - Partial bytes are discarded; no commit occurs.
  - spi_miso_oe = 0, spi_miso = 0.
- ena low: forces the same behaviour as cs_n high. The regfile is retained.
- Simultaneous synced rising edge and cs_n deassert: deassert wins and the bit is discarded.
- Total latency from the last SCLK rising edge at the pin to rx_valid high: SYNC_STAGES + 2 clk.

Optional Feature:
- Macro: SPI_TARGET_AUTOINC_EN.
- Defined: after each completed data byte, the FSM stays in DATA and addr increments modulo 8, wrapping from 7 to 0. Bursts of any length are therefore accepted.
  - Writes continue with rx_valid pulsing once per byte. Address 7 is still skipped for writes.
  - Reads reload shift_out from the new address on the 8th rising edge.
- Undefined: single data byte per frame; DATA -> DONE as described above.

Test Plan:
- Reset check: hold rst_n low 2 clk -> spi_miso_oe = 0, rx_valid = 0, dbg_data = 8'h00 for addresses 0-6 and 8'hA5 for address 7.
- Write: frame 8'h03, 8'h5C -> one rx_valid pulse with rx_addr = 3, rx_data = 8'h5C; then dbg_addr = 3 gives dbg_data = 8'h5C.
- Read-back: after the write, frame 8'h83, 8'h00 -> MISO bits captured on rising edges of byte 2 = 8'h5C. Byte 1 MISO = 8'h00.
- ID protection: write frame 8'h07, 8'hFF -> no rx_valid pulse; read 8'h87 returns 8'hA5.
- Abort: frame 8'h02 followed by 5 bits of 8'hFF, then cs_n high -> no rx_valid pulse, reg 2 unchanged, spi_miso_oe = 0 within SYNC_STAGES + 2 clk.
- Burst (with SPI_TARGET_AUTOINC_EN): frame 8'h06, 8'h11, 8'h22, 8'h33 -> reg6 = 8'h11, reg7 unchanged, reg0 = 8'h33, 2 rx_valid pulses. Without the macro: only reg6 = 8'h11 and 1 pulse.
